// File: rtl/multdiv_pkg.sv
// Shared constants for the multiply/divide sequencer: instruction field
// positions, opcode/ALU-op encodings, default exception codes and the
// sequencer state enum.
package multdiv_pkg;

    // Instruction field bit positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RD_MSB  = 26;
    localparam int RD_LSB  = 22;
    localparam int ALU_MSB = 6;
    localparam int ALU_LSB = 2;

    // Encodings
    localparam logic [4:0] OPC_RTYPE = 5'b00000;
    localparam logic [4:0] ALU_MUL   = 5'b00110;
    localparam logic [4:0] ALU_DIV   = 5'b00111;

    // Default exception reporting
    localparam int DEF_RSTATUS_REG  = 30;
    localparam int DEF_MUL_EXC_CODE = 4;
    localparam int DEF_DIV_EXC_CODE = 5;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_PEND = 2'd2
    } md_state_e;

endpackage

// File: rtl/md_insn_decode.sv
// Combinational decode of a 32-bit instruction into mul/div flags and rd.
// Shared between the sequencer and the pipeline stall logic.
module md_insn_decode
    import multdiv_pkg::*;
(
    input  logic [31:0] insn_i,
    output logic        is_md_o,
    output logic        is_div_o,
    output logic [4:0]  rd_o
);

    logic [4:0] opc;
    logic [4:0] alu;
    logic       unused_bits;

    assign opc         = insn_i[OPC_MSB:OPC_LSB];
    assign alu         = insn_i[ALU_MSB:ALU_LSB];
    assign rd_o        = insn_i[RD_MSB:RD_LSB];
    assign is_md_o     = (opc == OPC_RTYPE) && ((alu == ALU_MUL) || (alu == ALU_DIV));
    assign is_div_o    = (opc == OPC_RTYPE) && (alu == ALU_DIV);
    assign unused_bits = ^{insn_i[21:7], insn_i[1:0]};

endmodule

// File: rtl/multdiv_sequencer.sv
// Launch/track/write-back sequencer for the shared iterative mul/div unit.
// Optional feature: define MULTDIV_TIMEOUT_EN to abort a BUSY operation
// after TIMEOUT_CYCLES cycles without md_ready (reported as a div exception).
// The FSM state is held in state_q for observation.
module multdiv_sequencer
    import multdiv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 40,
    parameter int RSTATUS_REG    = DEF_RSTATUS_REG,
    parameter int MUL_EXC_CODE   = DEF_MUL_EXC_CODE,
    parameter int DIV_EXC_CODE   = DEF_DIV_EXC_CODE
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] dx_insn,
    input  logic        dx_valid,
    input  logic        pipe_stall,
    input  logic [31:0] dx_opA,
    input  logic [31:0] dx_opB,
    output logic        md_ctrl_mult,
    output logic        md_ctrl_div,
    output logic [31:0] md_opA,
    output logic [31:0] md_opB,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    input  logic        mw_wb_busy,
    output logic        wb_en,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        mult_ongoing,
    output logic [31:0] mult_insn
);

    md_state_e   state_q;
    logic [31:0] insn_q;
    logic [31:0] opa_q;
    logic [31:0] opb_q;
    logic        is_div_q;
    logic        first_q;
    logic        ctrl_mult_q;
    logic        ctrl_div_q;
    logic [4:0]  wb_reg_q;
    logic [31:0] wb_data_q;

    logic        dx_is_md;
    logic        dx_is_div;
    logic [4:0]  dx_rd_unused;
    logic [4:0]  insn_rd;

`ifdef MULTDIV_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

    md_insn_decode u_dx_decode (
        .insn_i   (dx_insn),
        .is_md_o  (dx_is_md),
        .is_div_o (dx_is_div),
        .rd_o     (dx_rd_unused)
    );

    assign insn_rd = insn_q[RD_MSB:RD_LSB];

    // Sequencer FSM: launch in IDLE, await completion in BUSY, hold the write in PEND
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            insn_q      <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            is_div_q    <= 1'b0;
            first_q     <= 1'b0;
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
            wb_reg_q    <= '0;
            wb_data_q   <= '0;
`ifdef MULTDIV_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
            first_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (dx_valid && dx_is_md && !pipe_stall) begin
                        state_q     <= ST_BUSY;
                        insn_q      <= dx_insn;
                        opa_q       <= dx_opA;
                        opb_q       <= dx_opB;
                        is_div_q    <= dx_is_div;
                        first_q     <= 1'b1;
                        ctrl_mult_q <= !dx_is_div;
                        ctrl_div_q  <= dx_is_div;
`ifdef MULTDIV_TIMEOUT_EN
                        cnt_q       <= '0;
`endif
                    end
                end
                ST_BUSY: begin
`ifdef MULTDIV_TIMEOUT_EN
                    cnt_q <= cnt_q + 1'b1;
`endif
                    // The unit cannot complete in the cycle its start pulse is seen
                    if (!first_q && md_ready) begin
                        if (md_exception) begin
                            wb_reg_q  <= 5'(RSTATUS_REG);
                            wb_data_q <= is_div_q ? 32'(DIV_EXC_CODE) : 32'(MUL_EXC_CODE);
                            state_q   <= ST_PEND;
                        end else if (insn_rd == 5'd0) begin
                            state_q <= ST_IDLE;
                            insn_q  <= '0;
                        end else begin
                            wb_reg_q  <= insn_rd;
                            wb_data_q <= md_result;
                            state_q   <= ST_PEND;
                        end
                    end
`ifdef MULTDIV_TIMEOUT_EN
                    else if ((cnt_q + 1'b1) == CW'(TIMEOUT_CYCLES)) begin
                        wb_reg_q  <= 5'(RSTATUS_REG);
                        wb_data_q <= 32'(DIV_EXC_CODE);
                        state_q   <= ST_PEND;
                    end
`endif
                end
                ST_PEND: begin
                    // MW owns the port when busy; our write commits on the first free cycle
                    if (!mw_wb_busy) begin
                        state_q <= ST_IDLE;
                        insn_q  <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign md_ctrl_mult = ctrl_mult_q;
    assign md_ctrl_div  = ctrl_div_q;
    assign md_opA       = opa_q;
    assign md_opB       = opb_q;
    assign wb_en        = (state_q == ST_PEND) && !mw_wb_busy;
    assign wb_reg       = wb_reg_q;
    assign wb_data      = wb_data_q;
    assign mult_ongoing = (state_q != ST_IDLE);
    assign mult_insn    = insn_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Self-checking bench for multdiv_sequencer. The bench plays the mul/div
// unit; expected register-file writes are queued at launch and compared by
// an independent monitor whenever wb_en is seen.
module tb_multdiv_sequencer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] dx_insn = '0;
    logic        dx_valid = 1'b0;
    logic        pipe_stall = 1'b0;
    logic [31:0] dx_opA = '0;
    logic [31:0] dx_opB = '0;
    logic        md_ctrl_mult;
    logic        md_ctrl_div;
    logic [31:0] md_opA;
    logic [31:0] md_opB;
    logic [31:0] md_result = '0;
    logic        md_exception = 1'b0;
    logic        md_ready = 1'b0;
    logic        mw_wb_busy = 1'b0;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        mult_ongoing;
    logic [31:0] mult_insn;

    int checks = 0;
    int errors = 0;
    logic [36:0] exp_q[$];
    logic [36:0] mon_e;

    // clock / reset
    always #5 clock = ~clock;

    multdiv_sequencer dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .dx_insn      (dx_insn),
        .dx_valid     (dx_valid),
        .pipe_stall   (pipe_stall),
        .dx_opA       (dx_opA),
        .dx_opB       (dx_opB),
        .md_ctrl_mult (md_ctrl_mult),
        .md_ctrl_div  (md_ctrl_div),
        .md_opA       (md_opA),
        .md_opB       (md_opB),
        .md_result    (md_result),
        .md_exception (md_exception),
        .md_ready     (md_ready),
        .mw_wb_busy   (mw_wb_busy),
        .wb_en        (wb_en),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .mult_ongoing (mult_ongoing),
        .mult_insn    (mult_insn)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Inputs are driven 1 time unit after the rising edge, checks run at +2
    task automatic slot();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [31:0] mk_insn(input bit is_div, input logic [4:0] rd);
        logic [14:0] mid;
        logic [1:0]  lo;
        mid = 15'($urandom);
        lo  = 2'($urandom);
        return {5'b00000, rd, mid, (is_div ? 5'b00111 : 5'b00110), lo};
    endfunction

    // scoreboard monitor: every register-file write must match the head of exp_q
    always @(posedge clock) begin
        #3;
        if (reset_n && wb_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got r%0d=0x%0h, expected no write at %0t",
                         wb_reg, wb_data, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("wb_reg", 32'(wb_reg), 32'(mon_e[36:32]));
                check("wb_data", wb_data, mon_e[31:0]);
            end
        end
    end

    // One complete operation: launch, unit latency, optional port conflict, write-back
    task automatic run_op(input bit is_div, input logic [4:0] rd, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input bit exc,
                          input int busy, input bit stray);
        logic [31:0] insn;
        logic [31:0] res;
        insn = mk_insn(is_div, rd);
        res  = is_div ? (a / b) : (a * b);
        // reference: what the register file must see for this operation
        if (exc) exp_q.push_back({5'd30, (is_div ? 32'd5 : 32'd4)});
        else if (rd != 5'd0) exp_q.push_back({rd, res});

        dx_insn = insn; dx_valid = 1'b1; pipe_stall = 1'b0; dx_opA = a; dx_opB = b;
        settle();
        check("idle_before_launch", 32'(mult_ongoing), 32'd0);

        slot();
        dx_valid = 1'b0; dx_opA = $urandom; dx_opB = $urandom;
        md_ready = stray; md_result = $urandom; md_exception = 1'b0;
        settle();
        check("pulse_mult", 32'(md_ctrl_mult), 32'(!is_div));
        check("pulse_div", 32'(md_ctrl_div), 32'(is_div));
        check("md_opA", md_opA, a);
        check("md_opB", md_opB, b);
        check("mult_insn", mult_insn, insn);
        check("ongoing_first", 32'(mult_ongoing), 32'd1);

        for (int i = 2; i <= lat; i++) begin
            slot();
            md_ready = 1'b0;
            if (stray) begin
                dx_valid = 1'b1; pipe_stall = 1'b0; dx_insn = mk_insn(1'($urandom), 5'd9);
            end
            settle();
            check("busy_ongoing", 32'(mult_ongoing), 32'd1);
            check("busy_no_pulse", 32'(md_ctrl_mult | md_ctrl_div), 32'd0);
            check("busy_insn", mult_insn, insn);
            check("busy_opA", md_opA, a);
            check("busy_no_wb", 32'(wb_en), 32'd0);
        end

        slot();
        dx_valid = 1'b0;
        md_ready = 1'b1; md_result = res; md_exception = exc;
        mw_wb_busy = (busy > 0);
        settle();
        check("ready_ongoing", 32'(mult_ongoing), 32'd1);

        slot();
        md_ready = 1'b0; md_exception = 1'b0; md_result = $urandom;
        if (!exc && rd == 5'd0) begin
            settle();
            check("rd0_idle", 32'(mult_ongoing), 32'd0);
            check("rd0_no_wb", 32'(wb_en), 32'd0);
        end else begin
            for (int k = 0; k < busy; k++) begin
                settle();
                check("conflict_no_wb", 32'(wb_en), 32'd0);
                check("conflict_ongoing", 32'(mult_ongoing), 32'd1);
                slot();
                mw_wb_busy = (k + 1 < busy);
            end
            settle();
            check("wb_en_high", 32'(wb_en), 32'd1);
            check("wb_ongoing", 32'(mult_ongoing), 32'd1);
            slot();
            settle();
            check("after_wb_idle", 32'(mult_ongoing), 32'd0);
            check("after_wb_no_wb", 32'(wb_en), 32'd0);
            check("after_wb_insn", mult_insn, 32'd0);
        end
    endtask

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // stimulus
    initial begin
        logic [31:0] a;
        logic [31:0] b;
        #3;
        check("rst_ongoing", 32'(mult_ongoing), 32'd0);
        check("rst_wb_en", 32'(wb_en), 32'd0);
        check("rst_pulse", 32'(md_ctrl_mult | md_ctrl_div), 32'd0);
        check("rst_insn", mult_insn, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        slot();
        slot();
        reset_n = 1'b1;
        slot();

        // directed cases
        run_op(1'b0, 5'd5, 32'd7, 32'd6, 10, 1'b0, 0, 1'b0);   // mul normal path
        run_op(1'b1, 5'd3, 32'd100, 32'd7, 4, 1'b1, 0, 1'b0);  // div exception
        run_op(1'b0, 5'd12, 32'd9, 32'd11, 3, 1'b0, 3, 1'b0);  // port conflict
        run_op(1'b0, 5'd0, 32'd3, 32'd4, 2, 1'b0, 0, 1'b0);    // rd = 0
        run_op(1'b0, 5'd8, 32'hFFFF_FFFF, 32'd2, 1, 1'b0, 0, 1'b1); // fastest completion, strays

        // no launch for a non-md instruction or a stalled mul
        dx_insn = {5'b00000, 5'd4, 15'd0, 5'b00000, 2'b00}; dx_valid = 1'b1;
        slot();
        settle();
        check("non_md_no_launch", 32'(mult_ongoing), 32'd0);
        dx_insn = {5'b00101, 5'd4, 15'd0, 5'b00110, 2'b00};
        slot();
        settle();
        check("bad_opcode_no_launch", 32'(mult_ongoing), 32'd0);
        dx_insn = mk_insn(1'b0, 5'd4); pipe_stall = 1'b1;
        slot();
        settle();
        check("stalled_no_launch", 32'(mult_ongoing), 32'd0);
        dx_valid = 1'b0; pipe_stall = 1'b0;
        slot();
        settle();
        check("bubble_no_launch", 32'(mult_ongoing), 32'd0);

        // reset in BUSY
        dx_insn = mk_insn(1'b0, 5'd7); dx_valid = 1'b1; dx_opA = 32'd5; dx_opB = 32'd5;
        slot();
        dx_valid = 1'b0;
        slot();
        slot();
        reset_n = 1'b0;
        settle();
        check("mid_rst_ongoing", 32'(mult_ongoing), 32'd0);
        check("mid_rst_pulse", 32'(md_ctrl_mult | md_ctrl_div), 32'd0);
        check("mid_rst_wb_en", 32'(wb_en), 32'd0);
        check("mid_rst_insn", mult_insn, 32'd0);
        check("mid_rst_opA", md_opA, 32'd0);
        check("mid_rst_opB", md_opB, 32'd0);
        check("mid_rst_wb_reg", 32'(wb_reg), 32'd0);
        slot();
        reset_n = 1'b1;
        slot();
        md_ready = 1'b1; md_result = 32'hDEAD_BEEF;
        settle();
        check("stray_ready_no_wb", 32'(wb_en), 32'd0);
        slot();
        md_ready = 1'b0;
        settle();
        check("stray_ready_idle", 32'(mult_ongoing), 32'd0);
        check("stray_ready_no_wb2", 32'(wb_en), 32'd0);
        slot();

`ifdef MULTDIV_TIMEOUT_EN
        // timeout: md_ready never arrives
        exp_q.push_back({5'd30, 32'd5});
        dx_insn = mk_insn(1'b0, 5'd6); dx_valid = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            slot();
            dx_valid = 1'b0;
            settle();
            check("to_busy_ongoing", 32'(mult_ongoing), 32'd1);
            check("to_busy_no_wb", 32'(wb_en), 32'd0);
        end
        slot();
        settle();
        check("to_wb_en", 32'(wb_en), 32'd1);
        slot();
        md_ready = 1'b1;
        settle();
        check("to_idle", 32'(mult_ongoing), 32'd0);
        check("to_stray_no_wb", 32'(wb_en), 32'd0);
        slot();
        md_ready = 1'b0;
`endif

        // randomized operations
        for (int n = 0; n < 24; n++) begin
            bit is_div;
            is_div = 1'($urandom);
            a = $urandom;
            b = is_div ? $urandom_range(1, 5000) : $urandom;
            run_op(is_div, 5'($urandom_range(0, 31)), a, b, $urandom_range(1, 8),
                   ($urandom_range(0, 4) == 0), $urandom_range(0, 3), 1'($urandom));
        end

        slot();
        slot();
        slot();
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
